// File: rtl/sccb_cfg_seq_pkg.sv
// Shared types and helpers for the table-driven SCCB register configurator.
// CFG_READBACK_EN adds the read-back verify states to the state encoding.
package sccb_cfg_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_LATCH   = 4'd2,
        ST_REQ     = 4'd3,
        ST_WAIT    = 4'd4,
        ST_DELAY   = 4'd5,
        ST_NEXT    = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERR     = 4'd8
`ifdef CFG_READBACK_EN
        ,
        ST_RD_REQ  = 4'd9,
        ST_RD_WAIT = 4'd10
`endif
    } state_e;

    localparam logic [15:0] DELAY_CODE_DEF = 16'hFFFF;
    localparam logic [7:0]  SCCB_RD_BIT    = 8'h01;

    function automatic logic state_busy(input state_e s);
        case (s)
            ST_IDLE, ST_DONE, ST_ERR: state_busy = 1'b0;
            default:                  state_busy = 1'b1;
        endcase
    endfunction

    // Wide enough for the largest delay entry (all-ones data times the unit).
    function automatic int delay_cnt_w(input int data_w, input int unit);
        return $clog2((2 ** data_w) * unit);
    endfunction

endpackage

// File: rtl/sccb_cfg_seq_delay_timer.sv
// Down-counter for in-table delay entries; expired is high on the last counted cycle,
// so a loaded value N keeps the sequencer waiting max(N,1) cycles.
module sccb_cfg_seq_delay_timer #(
    parameter int W = 8
) (
    input  logic         clk_100,
    input  logic         rst_100,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_100 or negedge rst_100) begin
        if (!rst_100) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q <= W'(1));

endmodule

// File: rtl/sccb_cfg_seq.sv
// Table-driven SCCB register configurator: walks the ROM table, issues writes via req/ack,
// handles delay entries and NACK retry. CFG_READBACK_EN adds a verify read after each write.
module sccb_cfg_seq
    import sccb_cfg_seq_pkg::*;
#(
    parameter logic [7:0]        DEV_ADDR   = 8'h78,
    parameter int                REG_AW     = 16,
    parameter int                DATA_W     = 8,
    parameter int                DEPTH      = 304,
    parameter int                AW         = 9,
    parameter logic [REG_AW-1:0] DELAY_CODE = REG_AW'(DELAY_CODE_DEF),
    parameter int                DELAY_UNIT = 100000,
    parameter int                MAX_RETRY  = 3,
    parameter bit                AUTO_START = 1'b1
) (
    input  logic                       clk_100,
    input  logic                       rst_100,
    input  logic                       start,
    output logic [AW-1:0]              rom_addr,
    input  logic [REG_AW+DATA_W-1:0]   rom_data,
    output logic                       i2c_req,
    output logic                       i2c_rnw,
    output logic [8+REG_AW+DATA_W-1:0] i2c_wdata,
    input  logic                       i2c_ack,
    input  logic                       i2c_nack,
    input  logic [DATA_W-1:0]          i2c_rdata,
    output logic                       busy,
    output logic                       cfg_done,
    output logic                       cfg_err,
    output logic [AW-1:0]              err_index
);

    localparam int ENT_W = REG_AW + DATA_W;
    localparam int WD_W  = 8 + ENT_W;
    localparam int DLY_W = delay_cnt_w(DATA_W, DELAY_UNIT);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e            state_q, state_d;
    logic [AW-1:0]     index_q, index_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic              auto_q, auto_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [AW-1:0]     err_index_q, err_index_d;
    logic [WD_W-1:0]   wdata_q, wdata_d;

    logic              start_s;
    logic [REG_AW-1:0] entry_reg_s;
    logic [DATA_W-1:0] entry_dat_s;
    logic              tmr_load_s;
    logic [DLY_W-1:0]  tmr_val_s;
    logic              tmr_expired_s;

    assign entry_reg_s = rom_data[ENT_W-1:DATA_W];
    assign entry_dat_s = rom_data[DATA_W-1:0];
    assign tmr_val_s   = DLY_W'(entry_dat_s) * DLY_W'(DELAY_UNIT);
    // A completing transfer takes priority over a coincident start request.
    assign start_s     = start & ~i2c_ack;

    sccb_cfg_seq_delay_timer #(
        .W (DLY_W)
    ) u_delay_timer (
        .clk_100 (clk_100),
        .rst_100 (rst_100),
        .load    (tmr_load_s),
        .value   (tmr_val_s),
        .expired (tmr_expired_s)
    );

`ifdef CFG_READBACK_EN
    logic rnw_q, rnw_d;
`else
    logic unused_rdata_s;
    assign unused_rdata_s = ^i2c_rdata;
`endif

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        retry_d     = retry_q;
        auto_d      = auto_q;
        done_d      = done_q;
        err_d       = err_q;
        err_index_d = err_index_q;
        wdata_d     = wdata_q;
        tmr_load_s  = 1'b0;
`ifdef CFG_READBACK_EN
        rnw_d       = rnw_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_s || auto_q) begin
                    state_d     = ST_FETCH;
                    index_d     = {AW{1'b0}};
                    retry_d     = {RTY_W{1'b0}};
                    auto_d      = 1'b0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    err_index_d = {AW{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                wdata_d = {DEV_ADDR & ~SCCB_RD_BIT, rom_data};
`ifdef CFG_READBACK_EN
                rnw_d   = 1'b0;
`endif
                if (entry_reg_s == DELAY_CODE) begin
                    state_d    = ST_DELAY;
                    tmr_load_s = 1'b1;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!i2c_ack) begin
                    state_d = ST_WAIT;
                end else if (!i2c_nack) begin
`ifdef CFG_READBACK_EN
                    state_d = ST_RD_REQ;
                    retry_d = {RTY_W{1'b0}};
                    rnw_d   = 1'b1;
                    wdata_d = {DEV_ADDR | SCCB_RD_BIT, wdata_q[ENT_W-1:0]};
`else
                    state_d = ST_NEXT;
`endif
                end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                    retry_d = retry_q + RTY_W'(1);
                    state_d = ST_REQ;
                end else begin
                    state_d     = ST_ERR;
                    err_d       = 1'b1;
                    err_index_d = index_q;
                end
            end
`ifdef CFG_READBACK_EN
            ST_RD_REQ: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (!i2c_ack) begin
                    state_d = ST_RD_WAIT;
                end else if (i2c_nack && (retry_q < RTY_W'(MAX_RETRY))) begin
                    retry_d = retry_q + RTY_W'(1);
                    state_d = ST_RD_REQ;
                end else if (i2c_nack || (i2c_rdata != wdata_q[DATA_W-1:0])) begin
                    state_d     = ST_ERR;
                    err_d       = 1'b1;
                    err_index_d = index_q;
                end else begin
                    state_d = ST_NEXT;
                end
            end
`endif
            ST_DELAY: begin
                if (tmr_expired_s) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_DELAY;
                end
            end
            ST_NEXT: begin
                retry_d = {RTY_W{1'b0}};
                if (index_q == AW'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    index_d = index_q + AW'(1);
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef CFG_READBACK_EN
    assign req_d = (state_d == ST_REQ) || (state_d == ST_RD_REQ);
`else
    assign req_d = (state_d == ST_REQ);
`endif
    assign busy_d = state_busy(state_d);

    // State and registered outputs.
    always_ff @(posedge clk_100 or negedge rst_100) begin
        if (!rst_100) begin
            state_q     <= ST_IDLE;
            index_q     <= {AW{1'b0}};
            retry_q     <= {RTY_W{1'b0}};
            auto_q      <= AUTO_START;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_index_q <= {AW{1'b0}};
            wdata_q     <= {WD_W{1'b0}};
`ifdef CFG_READBACK_EN
            rnw_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            retry_q     <= retry_d;
            auto_q      <= auto_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_index_q <= err_index_d;
            wdata_q     <= wdata_d;
`ifdef CFG_READBACK_EN
            rnw_q       <= rnw_d;
`endif
        end
    end

    assign rom_addr  = index_q;
    assign i2c_req   = req_q;
    assign i2c_wdata = wdata_q;
    assign busy      = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign err_index = err_index_q;
`ifdef CFG_READBACK_EN
    assign i2c_rnw   = rnw_q;
`else
    assign i2c_rnw   = 1'b0;
`endif

endmodule
